// File: rtl/lcd_char_responder_pkg.sv
// Shared definitions for the HD44780 character LCD responder:
// FSM encodings, init/config constants and default 50 MHz timing.
package lcd_defs;

    typedef enum logic [3:0] {
        ST_POWERON,
        ST_INIT,
        ST_INIT_WAIT,
        ST_CONFIG,
        ST_IDLE,
        ST_BYTE_HI,
        ST_GAP,
        ST_BYTE_LO,
        ST_POST_WAIT
    } lcdState_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EN,
        PH_HOLD
    } strobePhase_t;

    localparam int CNT_W = 20;

    localparam logic [3:0] INIT_NIB_3 = 4'h3;
    localparam logic [3:0] INIT_NIB_2 = 4'h2;

    localparam int LCD_POWERON    = 750000;
    localparam int LCD_WAIT_4100US = 205000;
    localparam int LCD_WAIT_100US = 5000;
    localparam int LCD_WAIT_40US  = 2000;
    localparam int LCD_WAIT_1640US = 82000;
    localparam int LCD_SETUP      = 2;
    localparam int LCD_EN         = 12;
    localparam int LCD_HOLD       = 1;
    localparam int LCD_NIB_GAP    = 50;

    // Function set 4-bit/2-line, entry mode, display on, clear.
    function automatic logic [7:0] cfgByte(input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0: b = 8'h28;
            2'd1: b = 8'h06;
            2'd2: b = 8'h0C;
            2'd3: b = 8'h01;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] initNibble(input logic [1:0] idx);
        return (idx == 2'd3) ? INIT_NIB_2 : INIT_NIB_3;
    endfunction

endpackage

// File: rtl/lcd_char_responder_strobe.sv
// One HD44780 nibble write: setup, E pulse, hold, then oDone.
// Ports: iStart/iNibble/iRS in; registered E/RS/DB pins, oDone, oBusy out.
module lcd_nibble_strobe
    import lcd_defs::*;
#(
    parameter int P_SETUP = LCD_SETUP,
    parameter int P_EN    = LCD_EN,
    parameter int P_HOLD  = LCD_HOLD
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [3:0] iNibble,
    input  logic       iRS,
    output logic       oEnable,
    output logic       oRS,
    output logic [3:0] oData,
    output logic       oDone,
    output logic       oBusy
);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(P_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EN    = CNT_W'(P_EN - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(P_HOLD - 1);

    strobePhase_t     phase;
    strobePhase_t     phaseNext;
    logic [CNT_W-1:0] cnt;
    logic             cntZero;

    assign cntZero = (cnt == '0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) phase <= PH_IDLE;
        else       phase <= phaseNext;
    end

    always_comb begin
        phaseNext = phase;
        unique case (phase)
            PH_IDLE:  if (iStart)  phaseNext = PH_SETUP;
            PH_SETUP: if (cntZero) phaseNext = PH_EN;
            PH_EN:    if (cntZero) phaseNext = PH_HOLD;
            PH_HOLD:  if (cntZero) phaseNext = PH_IDLE;
        endcase
    end

    always_comb begin
        oDone = (phase == PH_HOLD) && cntZero;
        oBusy = (phase != PH_IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (phaseNext != phase) begin
            unique case (phaseNext)
                PH_SETUP: cnt <= L_SETUP;
                PH_EN:    cnt <= L_EN;
                PH_HOLD:  cnt <= L_HOLD;
                default:  cnt <= '0;
            endcase
        end else if (!cntZero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Data/RS only load from idle, so DB never moves while E is high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oEnable <= 1'b0;
            oRS     <= 1'b0;
            oData   <= 4'h0;
        end else begin
            oEnable <= (phaseNext == PH_EN);
            if (phase == PH_IDLE && iStart) begin
                oData <= iNibble;
                oRS   <= iRS;
            end
        end
    end

endmodule

// File: rtl/lcd_char_responder.sv
// CPU->LCD byte responder: HD44780 4-bit init/config, then one byte per handshake.
// Ports: Clock/Reset, iData/iIsCommand/iData_Ready in; oReadyForData, LCD pins out.
module lcd_char_responder
    import lcd_defs::*;
#(
    parameter int P_POWERON     = LCD_POWERON,
    parameter int P_WAIT_4100US = LCD_WAIT_4100US,
    parameter int P_WAIT_100US  = LCD_WAIT_100US,
    parameter int P_WAIT_40US   = LCD_WAIT_40US,
    parameter int P_WAIT_1640US = LCD_WAIT_1640US,
    parameter int P_SETUP       = LCD_SETUP,
    parameter int P_EN          = LCD_EN,
    parameter int P_HOLD        = LCD_HOLD,
    parameter int P_NIB_GAP     = LCD_NIB_GAP
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iIsCommand,
    input  logic       iData_Ready,
    output logic       oReadyForData,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] L_POWERON = CNT_W'(P_POWERON - 1);
    localparam logic [CNT_W-1:0] L_4100    = CNT_W'(P_WAIT_4100US - 1);
    localparam logic [CNT_W-1:0] L_100     = CNT_W'(P_WAIT_100US - 1);
    localparam logic [CNT_W-1:0] L_40      = CNT_W'(P_WAIT_40US - 1);
    localparam logic [CNT_W-1:0] L_40_CLR  =
        CNT_W'(P_WAIT_40US + P_WAIT_1640US - 1);
    // The nibble gap runs from the high nibble's E fall, so the hold
    // cycle is part of it (requires P_NIB_GAP > P_HOLD).
    localparam logic [CNT_W-1:0] L_GAP     =
        CNT_W'(P_NIB_GAP - P_HOLD - 1);

    lcdState_t        state;
    lcdState_t        stateNext;
    logic [CNT_W-1:0] cnt;
    logic             cntZero;
    logic             armed;
    logic [1:0]       initIdx;
    logic [2:0]       cfgIdx;
    logic [7:0]       byteQ;
    logic             isCmdQ;
    logic             isClear;
    logic [CNT_W-1:0] initWait;
    logic             sStart;
    logic [3:0]       sNibble;
    logic             sRS;
    logic             sDone;
    logic             sBusy;

    assign cntZero  = (cnt == '0);
    assign isClear  = isCmdQ && (byteQ == 8'h01 || byteQ == 8'h02);
    assign initWait = (initIdx == 2'd0) ? L_4100 :
                      (initIdx == 2'd1) ? L_100  : L_40;

    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_POWERON;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            ST_POWERON:   if (armed && cntZero) stateNext = ST_INIT;
            ST_INIT:      if (sDone) stateNext = ST_INIT_WAIT;
            ST_INIT_WAIT: if (cntZero)
                              stateNext = (initIdx == 2'd3) ? ST_CONFIG : ST_INIT;
            ST_CONFIG:    stateNext = ST_BYTE_HI;
            ST_IDLE:      if (iData_Ready) stateNext = ST_BYTE_HI;
            ST_BYTE_HI:   if (sDone) stateNext = ST_GAP;
            ST_GAP:       if (cntZero) stateNext = ST_BYTE_LO;
            ST_BYTE_LO:   if (sDone) stateNext = ST_POST_WAIT;
            ST_POST_WAIT: if (cntZero)
                              stateNext = (cfgIdx == 3'd4) ? ST_IDLE : ST_CONFIG;
            default:      stateNext = ST_POWERON;
        endcase
    end

    // The low nibble is launched from the last gap cycle so that it
    // lands on the same edge the FSM enters BYTE_LO.
    always_comb begin
        sStart  = 1'b0;
        sNibble = 4'h0;
        sRS     = 1'b0;
        unique case (state)
            ST_INIT: begin
                sStart  = !sBusy;
                sNibble = initNibble(initIdx);
            end
            ST_BYTE_HI: begin
                sStart  = !sBusy;
                sNibble = byteQ[7:4];
                sRS     = !isCmdQ;
            end
            ST_GAP: begin
                sStart  = cntZero;
                sNibble = byteQ[3:0];
                sRS     = !isCmdQ;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) oReadyForData <= 1'b0;
        else       oReadyForData <= (stateNext == ST_IDLE);
    end

    // armed costs one extra power-on cycle but lets the counter
    // reset to 0 and still load the power-on delay.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            armed   <= 1'b0;
            initIdx <= 2'd0;
            cfgIdx  <= 3'd0;
            byteQ   <= 8'h00;
            isCmdQ  <= 1'b0;
        end else begin
            if (state == ST_POWERON && !armed) begin
                cnt   <= L_POWERON;
                armed <= 1'b1;
            end else if (stateNext != state) begin
                unique case (stateNext)
                    ST_INIT_WAIT: cnt <= initWait;
                    ST_GAP:       cnt <= L_GAP;
                    ST_POST_WAIT: cnt <= isClear ? L_40_CLR : L_40;
                    default:      cnt <= '0;
                endcase
            end else if (!cntZero) begin
                cnt <= cnt - 1'b1;
            end

            if (state == ST_INIT_WAIT && cntZero)
                initIdx <= initIdx + 1'b1;

            if (state == ST_CONFIG) begin
                byteQ  <= cfgByte(cfgIdx[1:0]);
                isCmdQ <= 1'b1;
                cfgIdx <= cfgIdx + 1'b1;
            end else if (state == ST_IDLE && iData_Ready) begin
                byteQ  <= iData;
                isCmdQ <= iIsCommand;
            end
        end
    end

    lcd_nibble_strobe #(
        .P_SETUP (P_SETUP),
        .P_EN    (P_EN),
        .P_HOLD  (P_HOLD)
    ) uStrobe (
        .Clock   (Clock),
        .Reset   (Reset),
        .iStart  (sStart),
        .iNibble (sNibble),
        .iRS     (sRS),
        .oEnable (oLCD_Enabled),
        .oRS     (oLCD_RegisterSelect),
        .oData   (oLCD_Data),
        .oDone   (sDone),
        .oBusy   (sBusy)
    );

endmodule

// File: tb/tb_lcd_char_responder.sv
// Self-checking bench for lcd_char_responder with short waits.
// E pulses are scored against an expected-nibble queue.
module tb_lcd_char_responder;

    logic       clk;
    logic       rst;
    logic [7:0] iData;
    logic       iIsCommand;
    logic       iData_Ready;
    logic       rdy;
    logic       lcdE;
    logic       lcdRS;
    logic       lcdRW;
    logic       lcdSF;
    logic [3:0] lcdD;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic       rs;
        logic [3:0] nib;
    } pulse_t;

    pulse_t expQ[$];

    typedef struct {
        logic [7:0] d;
        logic       cmd;
        int         ignoreAt;
        int         expCycles;
    } vec_t;

    lcd_char_responder #(
        .P_POWERON     (4),
        .P_WAIT_4100US (4),
        .P_WAIT_100US  (4),
        .P_WAIT_40US   (4),
        .P_WAIT_1640US (4),
        .P_SETUP       (2),
        .P_EN          (3),
        .P_HOLD        (1),
        .P_NIB_GAP     (4)
    ) dut (
        .Clock                   (clk),
        .Reset                   (rst),
        .iData                   (iData),
        .iIsCommand              (iIsCommand),
        .iData_Ready             (iData_Ready),
        .oReadyForData           (rdy),
        .oLCD_Enabled            (lcdE),
        .oLCD_RegisterSelect     (lcdRS),
        .oLCD_ReadWrite          (lcdRW),
        .oLCD_StrataFlashControl (lcdSF),
        .oLCD_Data               (lcdD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pushPulse(input logic rs, input logic [3:0] nib);
        pulse_t p;
        p.rs  = rs;
        p.nib = nib;
        expQ.push_back(p);
    endtask

    task automatic pushByte(input logic [7:0] d, input logic cmd);
        pushPulse(!cmd, d[7:4]);
        pushPulse(!cmd, d[3:0]);
    endtask

    task automatic pushInit();
        pushPulse(1'b0, 4'h3);
        pushPulse(1'b0, 4'h3);
        pushPulse(1'b0, 4'h3);
        pushPulse(1'b0, 4'h2);
        pushByte(8'h28, 1'b1);
        pushByte(8'h06, 1'b1);
        pushByte(8'h0C, 1'b1);
        pushByte(8'h01, 1'b1);
    endtask

    // Pin monitor: pulse shape, scoreboard, constant pins.
    logic       prevE;
    logic       prevRS;
    logic [3:0] prevD;
    logic       riseRS;
    logic [3:0] riseD;
    int         width;
    int         stable;

    always @(negedge clk) begin
        if (rst) begin
            prevE  = 1'b0;
            prevRS = lcdRS;
            prevD  = lcdD;
            width  = 0;
            stable = 0;
        end else begin
            vectors++;
            if (lcdRW !== 1'b0 || lcdSF !== 1'b1) begin
                miscompares++;
                $display("FAIL constPins: rw=%b sf=%b expected rw=0 sf=1",
                         lcdRW, lcdSF);
            end
            if (lcdD === prevD && lcdRS === prevRS) stable++;
            else stable = 0;
            if (lcdE && !prevE) begin
                pulse_t p;
                width  = 1;
                riseD  = lcdD;
                riseRS = lcdRS;
                chk("setupCycles>=2", (stable >= 2) ? 1 : 0, 1);
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpectedPulse: got rs=%b d=%h expected none",
                             lcdRS, lcdD);
                end else begin
                    p = expQ.pop_front();
                    if (p.rs !== lcdRS || p.nib !== lcdD) begin
                        miscompares++;
                        $display("FAIL pulse: got rs=%b d=%h expected rs=%b d=%h",
                                 lcdRS, lcdD, p.rs, p.nib);
                    end
                end
            end else if (lcdE && prevE) begin
                width++;
                if (lcdD !== riseD || lcdRS !== riseRS) begin
                    chk("dataMovedWhileE", {27'd0, lcdRS, lcdD},
                        {27'd0, riseRS, riseD});
                end
            end else if (!lcdE && prevE) begin
                chk("eWidth", width, 3);
                chk("holdData", {27'd0, lcdRS, lcdD}, {27'd0, riseRS, riseD});
            end
            prevE  = lcdE;
            prevD  = lcdD;
            prevRS = lcdRS;
        end
    end

    task automatic waitReady(input string name, input int budget);
        int n;
        n = 0;
        while (!rdy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            miscompares++;
            $display("FAIL %s: ready timeout after %0d cycles, expected 1", name, n);
        end
    endtask

    // Called #1 after an edge with rdy=1; offers one byte for a cycle and
    // returns edges from acceptance until ready is seen again.
    task automatic sendByte(input logic [7:0] d, input logic cmd,
                            input int ignoreAt, output int n);
        iData       = d;
        iIsCommand  = cmd;
        iData_Ready = 1'b1;
        pushByte(d, cmd);
        @(posedge clk);
        #1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                iData_Ready = 1'b0;
                chk("readyDrops", int'(rdy), 0);
            end
            if (n == 2) chk("latencyE0", int'(lcdE), 0);
            if (n == 3) chk("latencyE1", int'(lcdE), 1);
            if (ignoreAt != 0 && n == ignoreAt) begin
                iData       = 8'h99;
                iIsCommand  = !cmd;
                iData_Ready = 1'b1;
            end
            if (ignoreAt != 0 && n == ignoreAt + 1) iData_Ready = 1'b0;
        end while (!rdy && n < 200);
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        iData       = 8'h00;
        iIsCommand  = 1'b0;
        iData_Ready = 1'b0;

        vecs.push_back('{8'h41, 1'b0, 0, 20});
        vecs.push_back('{8'h01, 1'b1, 0, 24});
        vecs.push_back('{8'h80, 1'b1, 0, 20});
        vecs.push_back('{8'h7E, 1'b0, 0, 20});
        vecs.push_back('{8'h02, 1'b1, 0, 24});
        vecs.push_back('{8'h01, 1'b0, 0, 20});
        vecs.push_back('{8'hA5, 1'b0, 11, 20});

        repeat (3) @(posedge clk);
        #1;
        chk("rstReady", int'(rdy), 0);
        chk("rstE", int'(lcdE), 0);
        chk("rstRS", int'(lcdRS), 0);
        chk("rstData", int'(lcdD), 0);
        chk("rstRW", int'(lcdRW), 0);
        chk("rstSF", int'(lcdSF), 1);

        pushInit();
        @(negedge clk);
        rst = 1'b0;
        waitReady("bringUp", 2000);
        chk("initQueueEmpty", expQ.size(), 0);

        foreach (vecs[i]) begin
            sendByte(vecs[i].d, vecs[i].cmd, vecs[i].ignoreAt, n);
            chk($sformatf("byteCycles[%0d]", i), n, vecs[i].expCycles);
            chk($sformatf("byteQueueEmpty[%0d]", i), expQ.size(), 0);
        end

        // Level held for 100 cycles: accepts at edges 0,21,42,63,84.
        iData       = 8'h55;
        iIsCommand  = 1'b0;
        iData_Ready = 1'b1;
        for (int k = 0; k < 5; k++) pushByte(8'h55, 1'b0);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        iData_Ready = 1'b0;
        waitReady("heldLevel", 300);
        chk("heldQueueEmpty", expQ.size(), 0);

        // Reset while E is high on the high nibble.
        iData       = 8'h3C;
        iIsCommand  = 1'b0;
        iData_Ready = 1'b1;
        pushByte(8'h3C, 1'b0);
        @(posedge clk);
        #1;
        iData_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midByteE", int'(lcdE), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("asyncRstE", int'(lcdE), 0);
        chk("asyncRstReady", int'(rdy), 0);
        expQ.delete();
        pushInit();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitReady("reInit", 2000);
        chk("reInitQueueEmpty", expQ.size(), 0);

        sendByte(8'h4B, 1'b0, 0, n);
        chk("postResetByte", n, 20);
        chk("postResetQueueEmpty", expQ.size(), 0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
